// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - head-end master of the daisy-chained 16-bit register bus
//
// Turns one host request into a single bus beat at the chain head. It then waits
// for the matching beat at the chain tail and reports read data or a write ack.
// Optional watchdog: define BUS_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES cycles in WAIT without a matching return beat.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_addr_i/wdata_i/rw_i       host request fields (rw 1=write, 0=read)
//   req_valid_i, req_ready_o      host request handshake
//   resp_rdata_o/rw_o/valid_o     completion (rdata 0 for writes and timeouts)
//   resp_timeout_o                completion was a watchdog timeout
//   addr_o/wdata_o/rdata_o/rw_o/valid_o   beat driven to chain head
//   addr_i/wdata_i/rdata_i/rw_i/valid_i   beat returning from chain tail
module bus_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] resp_rdata_o,
    output logic        resp_rw_o,
    output logic        resp_valid_o,
    output logic        resp_timeout_o,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_ready, w_ready_nxt;
    logic [15:0] r_resp_rdata, w_resp_rdata_nxt;
    logic        r_resp_rw, w_resp_rw_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic        r_resp_timeout, w_resp_timeout_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [15:0] r_wdata, w_wdata_nxt;
    logic [15:0] r_rdata, w_rdata_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_match;
    logic        w_expire;
    logic        w_unused;

    // The bus outputs keep the last beat, so they double as the latched request.
    assign w_match = (r_state == S_WAIT) && valid_i && (addr_i == r_addr) && (rw_i == r_rw);

    // The tail copy of the write data is of no use to the initiator.
    assign w_unused = (^wdata_i) ^ (TIMEOUT_CYCLES > 0);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // The counter holds the number of unmatched WAIT cycles already spent.
    // The request expires on the edge that would otherwise be the last one
    // of a TIMEOUT_CYCLES-long WAIT.
    assign w_expire = (r_state == S_WAIT) && !w_match && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (!w_match) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt        = r_state;
        w_resp_rdata_nxt   = r_resp_rdata;
        w_resp_rw_nxt      = r_resp_rw;
        w_resp_valid_nxt   = 1'b0;
        w_resp_timeout_nxt = 1'b0;
        w_addr_nxt         = r_addr;
        w_wdata_nxt        = r_wdata;
        w_rdata_nxt        = r_rdata;
        w_rw_nxt           = r_rw;
        w_valid_nxt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_addr_nxt  = req_addr_i;
                    w_wdata_nxt = req_wdata_i;
                    w_rw_nxt    = req_rw_i;
                    w_rdata_nxt = 16'h0000;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_match) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rw_nxt    = r_rw;
                    w_resp_rdata_nxt = r_rw ? 16'h0000 : rdata_i;
                    w_state_nxt      = S_IDLE;
                end else if (w_expire) begin
                    w_resp_valid_nxt   = 1'b1;
                    w_resp_timeout_nxt = 1'b1;
                    w_resp_rw_nxt      = r_rw;
                    w_resp_rdata_nxt   = 16'h0000;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Ready rises together with the completion strobe.
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ready        <= 1'b1;
            r_resp_rdata   <= 16'h0000;
            r_resp_rw      <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_addr         <= 16'h0000;
            r_wdata        <= 16'h0000;
            r_rdata        <= 16'h0000;
            r_rw           <= 1'b0;
            r_valid        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ready        <= w_ready_nxt;
            r_resp_rdata   <= w_resp_rdata_nxt;
            r_resp_rw      <= w_resp_rw_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_timeout <= w_resp_timeout_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_rdata        <= w_rdata_nxt;
            r_rw           <= w_rw_nxt;
            r_valid        <= w_valid_nxt;
        end
    end

    assign req_ready_o    = r_ready;
    assign resp_rdata_o   = r_resp_rdata;
    assign resp_rw_o      = r_resp_rw;
    assign resp_valid_o   = r_resp_valid;
    assign resp_timeout_o = r_resp_timeout;
    assign addr_o         = r_addr;
    assign wdata_o        = r_wdata;
    assign rdata_o        = r_rdata;
    assign rw_o           = r_rw;
    assign valid_o        = r_valid;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - self-checking bench for bus_initiator
module tb_bus_initiator;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_rw = 1'b0, req_valid = 1'b0;
    logic        req_ready_o, resp_rw_o, resp_valid_o, resp_timeout_o;
    logic [15:0] resp_rdata_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic        b_rw, b_valid;

    // 0 = loopback, 1 = 3-node chain, 2 = bench-injected beats
    int          mode = 0;
    logic [15:0] inj_addr = '0, inj_rdata = '0;
    logic        inj_rw = 1'b0, inj_valid = 1'b0;

    logic        chain_init = 1'b1;
    logic [15:0] n_a [3], n_w [3], n_r [3], stor [3];
    logic        n_rw [3], n_v [3];
    logic [15:0] node_addr [3];
    assign node_addr[0] = 16'h0010;
    assign node_addr[1] = 16'h0001;
    assign node_addr[2] = 16'h0020;

    typedef struct {
        logic [15:0] rdata;
        logic        rw;
        logic        to;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rw_i(req_rw),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .resp_rdata_o(resp_rdata_o), .resp_rw_o(resp_rw_o),
        .resp_valid_o(resp_valid_o), .resp_timeout_o(resp_timeout_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(b_addr), .wdata_i(b_wdata), .rdata_i(b_rdata), .rw_i(b_rw), .valid_i(b_valid)
    );

    // Chain of one-cycle nodes; a node substitutes its stored value on reads of
    // its address and captures writes. Not tied to rst so beats survive a reset.
    always @(posedge clk) begin
        if (chain_init) begin
            stor[0] <= 16'h5555; stor[1] <= 16'h1234; stor[2] <= 16'hAAAA;
            for (int k = 0; k < 3; k++) n_v[k] <= 1'b0;
        end else begin
            n_a[0] <= addr_o; n_w[0] <= wdata_o; n_rw[0] <= rw_o; n_v[0] <= valid_o;
            n_r[0] <= (valid_o && addr_o == node_addr[0] && !rw_o) ? stor[0] : rdata_o;
            if (valid_o && addr_o == node_addr[0] && rw_o) stor[0] <= wdata_o;
            for (int k = 1; k < 3; k++) begin
                n_a[k] <= n_a[k-1]; n_w[k] <= n_w[k-1]; n_rw[k] <= n_rw[k-1]; n_v[k] <= n_v[k-1];
                n_r[k] <= (n_v[k-1] && n_a[k-1] == node_addr[k] && !n_rw[k-1]) ? stor[k] : n_r[k-1];
                if (n_v[k-1] && n_a[k-1] == node_addr[k] && n_rw[k-1]) stor[k] <= n_w[k-1];
            end
        end
    end

    always_comb begin
        b_addr = inj_addr; b_wdata = 16'h0000; b_rdata = inj_rdata; b_rw = inj_rw; b_valid = inj_valid;
        if (mode == 0) begin
            b_addr = addr_o; b_wdata = wdata_o; b_rdata = rdata_o; b_rw = rw_o; b_valid = valid_o;
        end else if (mode == 1) begin
            b_addr = n_a[2]; b_wdata = n_w[2]; b_rdata = n_r[2]; b_rw = n_rw[2]; b_valid = n_v[2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion must have been predicted.
    always @(negedge clk) begin
        if (!rst && resp_valid_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_resp observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", 32'(resp_rdata_o), 32'(e.rdata));
                chk("resp_rw", 32'(resp_rw_o), 32'(e.rw));
                chk("resp_timeout", 32'(resp_timeout_o), 32'(e.to));
            end
        end
    end

    // Presents a request, checks the head beat; returns at the negedge after E0.
    task automatic start_req(input logic [15:0] a, input logic [15:0] wd, input logic rw,
                             input logic [15:0] exp_rd, input logic exp_to);
        exp_t e;
        @(negedge clk);
        chk("req_ready_before", 32'(req_ready_o), 32'd1);
        req_addr = a; req_wdata = wd; req_rw = rw; req_valid = 1'b1;
        e.rdata = exp_rd; e.rw = rw; e.to = exp_to;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("beat_valid", 32'(valid_o), 32'd1);
        chk("beat_addr", 32'(addr_o), 32'(a));
        chk("beat_rw", 32'(rw_o), 32'(rw));
        chk("beat_rdata", 32'(rdata_o), 32'd0);
        if (rw) chk("beat_wdata", 32'(wdata_o), 32'(wd));
        chk("ready_in_wait", 32'(req_ready_o), 32'd0);
    endtask

    task automatic wait_resp(input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) chk("beat_one_cycle", 32'(valid_o), 32'd0);
            if (resp_valid_o) break;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ready_with_resp", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chain_init = 1'b0;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_addr_o", 32'(addr_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_timeout", 32'(resp_timeout_o), 32'd0);
        rst = 1'b0;

        // Loopback write
        mode = 0;
        start_req(16'h0003, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        wait_resp(1);

        // Chain read of a mapped node, then an unmapped address
        mode = 1;
        start_req(16'h0001, 16'h0000, 1'b0, 16'h1234, 1'b0);
        wait_resp(4);
        start_req(16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        wait_resp(4);
        // Write through chain then read back
        start_req(16'h0020, 16'hC0DE, 1'b1, 16'h0000, 1'b0);
        wait_resp(4);
        start_req(16'h0020, 16'h0000, 1'b0, 16'hC0DE, 1'b0);
        wait_resp(4);

`ifdef BUS_TIMEOUT_EN
        mode = 2;
        inj_valid = 1'b0;
        start_req(16'h0002, 16'h0000, 1'b0, 16'h0000, 1'b1);
        wait_resp(8);
        mode = 0;
        start_req(16'h0004, 16'h0101, 1'b1, 16'h0000, 1'b0);
        wait_resp(1);
`endif

        // Non-matching beats in WAIT, then a match; IDLE beats ignored
        mode = 2;
        start_req(16'h0001, 16'h0000, 1'b0, 16'hABCD, 1'b0);
        inj_valid = 1'b1; inj_addr = 16'h0005; inj_rw = 1'b0; inj_rdata = 16'h1111;
        @(negedge clk);
        chk("bad_addr_ignored", 32'(resp_valid_o), 32'd0);
        inj_addr = 16'h0001; inj_rw = 1'b1;
        @(negedge clk);
        chk("bad_rw_ignored", 32'(resp_valid_o), 32'd0);
        chk("still_waiting", 32'(req_ready_o), 32'd0);
        inj_rw = 1'b0; inj_rdata = 16'hABCD;
        @(negedge clk);
        chk("good_beat_resp", 32'(resp_valid_o), 32'd1);
        inj_rdata = 16'h2222;
        repeat (2) begin
            @(negedge clk);
            chk("idle_beat_ignored", 32'(resp_valid_o), 32'd0);
        end
        inj_valid = 1'b0;

        // Reset two cycles into WAIT
        mode = 1;
        start_req(16'h0001, 16'h0000, 1'b0, 16'h1234, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(req_ready_o), 32'd1);
        chk("async_rst_addr_o", 32'(addr_o), 32'd0);
        chk("async_rst_resp_rdata", 32'(resp_rdata_o), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("late_beat_ignored", 32'(resp_valid_o), 32'd0);
        end
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
